sync_fifo_prog: RTL

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ptr.sv | 22 ++
 rtl/sync_fifo_prog.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants, operation encoding and the count-width helper for the programmable sync FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned ERR_CNT_W = 8;

  // Encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrap-around FIFO pointer: advances by one on inc and returns to 0 after DEPTH-1.
module sync_fifo_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with registered read data, status pulses and programmable level flags.
// Define SYNC_FIFO_ERR_CNT_EN to add saturating overflow/underflow event counters.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_DEPTH,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
`ifdef SYNC_FIFO_ERR_CNT_EN
  input  logic                            err_clr,
  output logic [ERR_CNT_W-1:0]            ovf_cnt,
  output logic [ERR_CNT_W-1:0]            udf_cnt,
`endif
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    count
);

  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  generate
    if (FIFO_DEPTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH) begin : g_bad_params
      $error("sync_fifo_prog: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  fifo_op_e              op;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  always_comb begin
    wr_acc = wr_en && (!full || rd_en);
    rd_acc = rd_en && !empty;
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
      rd_valid  <= rd_acc;
      wr_ack    <= wr_acc;
      overflow  <= wr_en && full && !rd_en;
      underflow <= rd_en && empty;
    end
  end

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

`ifdef SYNC_FIFO_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (err_clr) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_en && !wr_acc && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      if (rd_en && !rd_acc && udf_cnt != '1) udf_cnt <= udf_cnt + 1'b1;
    end
  end
`endif

endmodule
